// File: rtl/cut_seq_pkg.sv
// Shared types and width helpers for the CUT I/O sequencer.
package cut_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_RESULT  = 3'd4,
    ST_DRAIN   = 3'd5
  } seq_state_e;

  localparam int DEF_IN_DEPTH       = 48;
  localparam int DEF_OUT_DEPTH      = 16;
  localparam int DEF_COMPUTE_CYCLES = 12;
  localparam int DEF_DIV            = 1;

  // Counter/address width for a range of n values; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cut_io_sequencer_tick_gen.sv
// Free-running clock-enable divider: cut_tick is high on the last count of every DIV cycles.
module cut_tick_gen
  import cut_seq_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic cut_tick
);

  localparam int DW = addr_w(DIV);
  localparam logic [DW-1:0] CNT_LAST = DW'(DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cut_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/cut_io_sequencer.sv
// Batch I/O sequencer for the CUT wrapper: collect, load, compute, capture, drain.
// Optional CUT_SEQ_BATCH_CNT_EN adds a 16-bit completed-batch counter output.
module cut_io_sequencer
  import cut_seq_pkg::*;
#(
  parameter int IN_DEPTH       = DEF_IN_DEPTH,
  parameter int OUT_DEPTH      = DEF_OUT_DEPTH,
  parameter int COMPUTE_CYCLES = DEF_COMPUTE_CYCLES,
  parameter int DIV            = DEF_DIV
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         val_input,
  input  logic                         abort,
  output logic                         re_i,
  output logic [addr_w(IN_DEPTH)-1:0]  in_addr,
  output logic                         cut_tick,
  output logic                         load_input,
  output logic                         load_result,
  output logic                         we,
  output logic [addr_w(OUT_DEPTH)-1:0] out_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
`ifdef CUT_SEQ_BATCH_CNT_EN
  ,
  output logic [15:0]                  batch_cnt
`endif
);

  localparam int IN_AW  = addr_w(IN_DEPTH);
  localparam int OUT_AW = addr_w(OUT_DEPTH);
  localparam int CMP_W  = addr_w(COMPUTE_CYCLES);
  localparam logic [IN_AW-1:0]  IN_LAST  = IN_AW'(IN_DEPTH - 1);
  localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(OUT_DEPTH - 1);
  localparam logic [CMP_W-1:0]  CMP_LAST = CMP_W'(COMPUTE_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [IN_AW-1:0]  in_addr_q, in_addr_d;
  logic [OUT_AW-1:0] out_addr_q, out_addr_d;
  logic [CMP_W-1:0]  cmp_cnt_q, cmp_cnt_d;
  logic re_i_q, re_i_d, load_input_q, load_input_d, load_result_q, load_result_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;

  cut_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .cut_tick (cut_tick)
  );

  always_comb begin
    state_d    = state_q;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    cmp_cnt_d  = cmp_cnt_q;
    done_d     = 1'b0;
    // Words offered while the FIFO is not being read are dropped and flagged.
    overrun_d  = overrun_q | (val_input & ~re_i_q);

    unique case (state_q)
      ST_IDLE: begin
        if (val_input) begin
          if (in_addr_q == IN_LAST) begin
            in_addr_d = '0;
            state_d   = ST_WAIT;
          end else begin
            in_addr_d = in_addr_q + IN_AW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cut_tick) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cmp_cnt_d = '0;
        state_d   = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (cut_tick) begin
          if (cmp_cnt_q == CMP_LAST) begin
            cmp_cnt_d = '0;
            state_d   = ST_RESULT;
          end else begin
            cmp_cnt_d = cmp_cnt_q + CMP_W'(1);
          end
        end
      end
      ST_RESULT: begin
        out_addr_d = '0;
        state_d    = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_addr_q == OUT_LAST) begin
          out_addr_d = '0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          out_addr_d = out_addr_q + OUT_AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      in_addr_d  = '0;
      out_addr_d = '0;
      cmp_cnt_d  = '0;
      done_d     = 1'b0;
      overrun_d  = 1'b0;
    end

    // Strobes decoded from the next state so they register in step with it.
    re_i_d        = (state_d == ST_IDLE);
    load_input_d  = (state_d == ST_LOAD);
    load_result_d = (state_d == ST_RESULT);
    we_d          = (state_d == ST_DRAIN);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      in_addr_q     <= '0;
      out_addr_q    <= '0;
      cmp_cnt_q     <= '0;
      re_i_q        <= 1'b1;
      load_input_q  <= 1'b0;
      load_result_q <= 1'b0;
      we_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_addr_q     <= in_addr_d;
      out_addr_q    <= out_addr_d;
      cmp_cnt_q     <= cmp_cnt_d;
      re_i_q        <= re_i_d;
      load_input_q  <= load_input_d;
      load_result_q <= load_result_d;
      we_q          <= we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef CUT_SEQ_BATCH_CNT_EN
  logic [15:0] batch_cnt_q, batch_cnt_d;

  always_comb begin
    batch_cnt_d = done_d ? batch_cnt_q + 16'd1 : batch_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) batch_cnt_q <= '0;
    else      batch_cnt_q <= batch_cnt_d;
  end

  assign batch_cnt = batch_cnt_q;
`endif

  assign re_i        = re_i_q;
  assign in_addr     = in_addr_q;
  assign out_addr    = out_addr_q;
  assign load_input  = load_input_q;
  assign load_result = load_result_q;
  assign we          = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule
